// File: rtl/voice_mixer_pkg.sv
// Shared defaults, state encoding and saturation helper for the voice mixer.
package mixer_pkg;

  localparam int DEF_NUM_VOICES     = 24;
  localparam int DEF_PHASE_WIDTH    = 32;
  localparam int DEF_LUT_ADDR_WIDTH = 8;
  localparam int DEF_SAMPLE_WIDTH   = 16;
  localparam int DEF_LUT_LATENCY    = 2;
  localparam int DEF_MIX_SHIFT      = 3;

  // Headroom for summing every voice at full scale without wrapping.
  localparam int ACC_WIDTH = DEF_SAMPLE_WIDTH + $clog2(DEF_NUM_VOICES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } mix_state_t;

  // Clamp a signed value to the range of a signed 'width'-bit word.
  // The result stays 32 bits wide; the caller keeps the low 'width' bits.
  function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      sat_narrow = hi;
    end else if (value < lo) begin
      sat_narrow = lo;
    end else begin
      sat_narrow = value;
    end
  endfunction

endpackage

// File: rtl/voice_mixer_tag_pipe.sv
// Delay line carrying {valid, gate} alongside an in-flight LUT read so the
// accumulator knows when read data belongs to a voice and whether it counts.
module mix_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  input  logic push_gate,
  output logic tag_valid,
  output logic tag_gate
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] gate_sr;

  // Shift the tag one stage per clock; stage 0 takes the new push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      gate_sr  <= '0;
    end else begin
      valid_sr[0] <= push_valid;
      gate_sr[0]  <= push_gate;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        gate_sr[i]  <= gate_sr[i-1];
      end
    end
  end

  assign tag_valid = valid_sr[DEPTH-1];
  assign tag_gate  = gate_sr[DEPTH-1];

endmodule

// File: rtl/voice_mixer.sv
// Per-sample voice mixer: snapshots all voices on a tick, reads each voice's
// waveform value from a shared LUT one voice per clock, sums the gated ones,
// then scales and saturates into one signed PCM sample.
//
// Interface protocol: sample_tick_in is a one-cycle request accepted only in
// IDLE (a tick at any other time is dropped and sets the sticky overrun_out).
// sample_valid_out is a one-cycle strobe with no back-pressure; sample_out and
// active_count_out hold their value until the next strobe.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES     = DEF_NUM_VOICES,
  parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
  parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int LUT_LATENCY    = DEF_LUT_LATENCY,
  parameter int MIX_SHIFT      = DEF_MIX_SHIFT
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   sample_tick_in,
  input  logic [NUM_VOICES-1:0]                  gate_in,
  input  logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase_value_in,
  output logic [LUT_ADDR_WIDTH-1:0]              lut_addr_out,
  input  logic signed [SAMPLE_WIDTH-1:0]         lut_data_in,
  output logic signed [SAMPLE_WIDTH-1:0]         sample_out,
  output logic                                   sample_valid_out,
  output logic [4:0]                             active_count_out,
  output logic                                   busy_out,
  output logic                                   overrun_out
);

  localparam int IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W   = SAMPLE_WIDTH + $clog2(NUM_VOICES);
  localparam int DRAIN_W = $clog2(LUT_LATENCY + 1) + 1;

  mix_state_t                 state;
  logic [NUM_VOICES-1:0]      snap_gate;
  logic [LUT_ADDR_WIDTH-1:0]  snap_addr [NUM_VOICES];
  logic [IDX_W-1:0]           idx;
  logic [DRAIN_W-1:0]         drain_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    lut_ext;
  logic signed [ACC_W-1:0]    acc_shifted;
  logic signed [31:0]         sat_wide;
  logic signed [SAMPLE_WIDTH-1:0] sample_next;
  logic [4:0]                 gate_count;
  logic                       issue_valid;
  logic                       issue_gate;
  logic                       tag_valid;
  logic                       tag_gate;
  logic                       tick_accept;
  logic                       unused_bits;

  assign tick_accept = sample_tick_in && (state == IDLE);
  assign busy_out    = (state != IDLE);

  // Capture gates and LUT addresses of every voice when a tick is accepted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      snap_gate <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_addr[i] <= '0;
      end
    end else if (tick_accept) begin
      snap_gate <= gate_in;
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_addr[i] <= phase_value_in[i][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
      end
    end
  end

  // Mix sequencer: issue one voice per clock, drain the LUT pipe, publish.
  // DRAIN lasts LUT_LATENCY+1 cycles because the address register adds one
  // stage in front of the LUT read latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick_in) begin
            state <= ISSUE;
            idx   <= '0;
          end
        end
        ISSUE: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NUM_VOICES - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_W'(LUT_LATENCY)) begin
            state <= OUTPUT;
          end
        end
        OUTPUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Issue stage: register the LUT address and the matching tag together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lut_addr_out <= '0;
      issue_valid  <= 1'b0;
      issue_gate   <= 1'b0;
    end else if (state == ISSUE) begin
      lut_addr_out <= snap_addr[idx];
      issue_valid  <= 1'b1;
      issue_gate   <= snap_gate[idx];
    end else begin
      issue_valid  <= 1'b0;
      issue_gate   <= 1'b0;
    end
  end

  mix_tag_pipe #(
    .DEPTH (LUT_LATENCY)
  ) u_tag_pipe (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .push_valid (issue_valid),
    .push_gate  (issue_gate),
    .tag_valid  (tag_valid),
    .tag_gate   (tag_gate)
  );

  assign lut_ext = {{(ACC_W - SAMPLE_WIDTH){lut_data_in[SAMPLE_WIDTH-1]}}, lut_data_in};

  // Accumulate LUT data whose tag arrives; gated-off voices add zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc <= '0;
    end else if (tick_accept) begin
      acc <= '0;
    end else if (tag_valid) begin
      acc <= acc + (tag_gate ? lut_ext : '0);
    end
  end

  // Scale and saturate the finished sum.
  always_comb begin
    acc_shifted = acc >>> MIX_SHIFT;
    sat_wide    = sat_narrow(32'(acc_shifted), SAMPLE_WIDTH);
    sample_next = sat_wide[SAMPLE_WIDTH-1:0];
  end

  // Count gated voices in the snapshot.
  always_comb begin
    gate_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      gate_count = gate_count + 5'(snap_gate[i]);
    end
  end

  // Publish the sample with a one-cycle strobe in OUTPUT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      active_count_out <= '0;
    end else begin
      sample_valid_out <= 1'b0;
      if (state == OUTPUT) begin
        sample_out       <= sample_next;
        sample_valid_out <= 1'b1;
        active_count_out <= gate_count;
      end
    end
  end

  // Sticky flag for ticks that arrive while a mix is still running.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out <= 1'b0;
    end else if (sample_tick_in && (state != IDLE)) begin
      overrun_out <= 1'b1;
    end
  end

  // Low phase bits and the upper saturation bits are deliberately not used.
  assign unused_bits = ^{phase_value_in, sat_wide};

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a two-cycle LUT model.
module tb_voice_mixer;

  localparam int NV = 24;

  logic                  clk;
  logic                  rst_n;
  logic                  sample_tick;
  logic [NV-1:0]         gate;
  logic [NV-1:0][31:0]   phase;
  logic [7:0]            lut_addr;
  logic signed [15:0]    lut_data;
  logic signed [15:0]    lut_d1;
  logic signed [15:0]    sample;
  logic                  sample_valid;
  logic [4:0]            active_count;
  logic                  busy;
  logic                  overrun;

  logic signed [15:0]    lut_tab [256];
  logic [NV-1:0][31:0]   snap_phase;

  int checks = 0;
  int errors = 0;
  int lat;
  int vcount;
  int addr_bad;
  logic busy_seen;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  voice_mixer dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .sample_tick_in   (sample_tick),
    .gate_in          (gate),
    .phase_value_in   (phase),
    .lut_addr_out     (lut_addr),
    .lut_data_in      (lut_data),
    .sample_out       (sample),
    .sample_valid_out (sample_valid),
    .active_count_out (active_count),
    .busy_out         (busy),
    .overrun_out      (overrun)
  );

  // Sine LUT model: two-cycle read latency from a programmable table.
  always @(posedge clk) begin
    lut_d1   <= lut_tab[lut_addr];
    lut_data <= lut_d1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one tick, then watch a fixed 41-cycle window. Cycle n is sampled
  // at the falling edge after the n-th rising edge following the tick edge.
  task automatic run_mix(input int tick2_at, input int change_at);
    lat = -1;
    vcount = 0;
    addr_bad = 0;
    busy_seen = 1'b0;
    @(negedge clk);
    snap_phase = phase;
    sample_tick = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      sample_tick = (tick2_at > 0) && (n == tick2_at);
      if (n >= 1 && n <= NV && lut_addr !== snap_phase[n-1][31:24]) addr_bad++;
      if (n == 1) busy_seen = busy;
      if (sample_valid) begin
        vcount++;
        if (lat < 0) lat = n;
      end
      if (change_at > 0 && n == change_at) begin
        for (int i = 0; i < NV; i++) phase[i] = 32'h2000_0000;
        gate = '1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sample_tick = 1'b0;
    gate = '0;
    phase = '0;
    for (int i = 0; i < 256; i++) lut_tab[i] = 16'($urandom_range(0, 65535));
    repeat (3) @(negedge clk);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_count", active_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_addr", lut_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single voice at full scale, random phases elsewhere.
    for (int i = 0; i < NV; i++) phase[i] = $urandom;
    gate = '0;
    gate[5] = 1'b1;
    phase[5] = 32'h40AB_CDEF;
    lut_tab[8'h40] = 16'sh7FFF;
    run_mix(0, 0);
    check("single_latency", lat, 28);
    check("single_sample", sample, 4095);
    check("single_count", active_count, 1);
    check("single_pulses", vcount, 1);
    check("single_busy_run", busy_seen, 1);
    check("single_busy_idle", busy, 0);
    check("single_addr_seq", addr_bad, 0);

    // Positive saturation.
    gate = '1;
    for (int i = 0; i < NV; i++) begin
      phase[i] = $urandom;
      phase[i][31:24] = 8'h11;
    end
    lut_tab[8'h11] = 16'sh7FFF;
    run_mix(0, 0);
    check("possat_sample", sample, 32767);
    check("possat_count", active_count, 24);

    // Negative saturation.
    lut_tab[8'h11] = 16'sh8000;
    run_mix(0, 0);
    check("negsat_sample", sample, -32768);
    check("negsat_count", active_count, 24);

    // Cancelling halves.
    for (int i = 0; i < NV; i++) phase[i][31:24] = (i < 12) ? 8'h21 : 8'h22;
    lut_tab[8'h21] = 16'sd1000;
    lut_tab[8'h22] = -16'sd1000;
    run_mix(0, 0);
    check("cancel_sample", sample, 0);
    check("cancel_latency", lat, 28);

    // Small in-range sum; ungated voices point at a full-scale entry.
    gate = 24'h000007;
    for (int i = 0; i < NV; i++) phase[i] = 32'h7F00_0000;
    phase[0] = 32'h3100_0000;
    phase[1] = 32'h3200_0000;
    phase[2] = 32'h3300_0000;
    lut_tab[8'h7F] = 16'sh7FFF;
    lut_tab[8'h31] = 16'sd100;
    lut_tab[8'h32] = 16'sd200;
    lut_tab[8'h33] = 16'sd300;
    run_mix(0, 0);
    check("small_sample", sample, 75);
    check("small_count", active_count, 3);

    // Last voice only, value -1: arithmetic shift keeps -1.
    gate = '0;
    gate[23] = 1'b1;
    phase[23] = 32'h4400_0000;
    lut_tab[8'h44] = -16'sd1;
    run_mix(0, 0);
    check("last_voice_sample", sample, -1);
    check("last_voice_count", active_count, 1);

    // Gate masking: LUT still sequenced, nothing summed.
    gate = '0;
    for (int i = 0; i < NV; i++) phase[i] = 32'hFF00_0000;
    lut_tab[8'hFF] = 16'sh1234;
    run_mix(0, 0);
    check("mask_sample", sample, 0);
    check("mask_count", active_count, 0);
    check("mask_addr_seq", addr_bad, 0);
    check("mask_latency", lat, 28);
    check("mask_overrun", overrun, 0);

    // Overrun plus mid-mix input change.
    gate = '0;
    gate[0] = 1'b1;
    for (int i = 0; i < NV; i++) phase[i] = 32'h1000_0000;
    lut_tab[8'h10] = 16'sd800;
    lut_tab[8'h20] = 16'sh7FFF;
    run_mix(10, 5);
    check("ovr_sample", sample, 100);
    check("ovr_count", active_count, 1);
    check("ovr_pulses", vcount, 1);
    check("ovr_latency", lat, 28);
    check("ovr_flag", overrun, 1);
    repeat (20) @(negedge clk);
    check("ovr_sticky", overrun, 1);

    // Another mix while the flag stays set.
    gate = '0;
    gate[3] = 1'b1;
    for (int i = 0; i < NV; i++) phase[i] = 32'h3300_0000;
    lut_tab[8'h33] = 16'sd256;
    run_mix(0, 0);
    check("post_ovr_sample", sample, 32);
    check("post_ovr_flag", overrun, 1);

    // Reset in the middle of a mix.
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sample", sample, 0);
    check("midrst_valid", sample_valid, 0);
    check("midrst_count", active_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_addr", lut_addr, 0);
    vcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_valid) vcount++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) vcount++;
    end
    check("midrst_no_pulse", vcount, 0);

    run_mix(0, 0);
    check("after_rst_sample", sample, 32);
    check("after_rst_count", active_count, 1);
    check("after_rst_latency", lat, 28);
    check("after_rst_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
